// File: rtl/cla_adder_pipe_pkg.sv
// cla_adder_pipe_pkg: shared defaults, group count and flag-bit indices for the CLA adder pipeline.
package cla_adder_pipe_pkg;
    localparam int CLA_WIDTH = 32;
    localparam int CLA_GROUP = 4;
    localparam int NGROUP = CLA_WIDTH / CLA_GROUP;
    typedef enum logic [1:0] {COUT, OVF, ZERO} flag_e;
endpackage

// File: rtl/cla_adder_pipe_group_unit.sv
// cla_group_unit: N-bit lookahead unit returning per-bit carries in, group propagate and group generate.
module cla_group_unit #(
    parameter int N = 4
) (
    input  logic [N-1:0] p,
    input  logic [N-1:0] g,
    input  logic         cin,
    output logic [N-1:0] c,
    output logic         gp,
    output logic         gg
);
    // c[i] uses the prefix P/G of bits below i, so cin never ripples through bits
    always_comb begin
        gg = 1'b0;
        gp = 1'b1;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c[i] = gg | (gp & cin);
            gg = g[i] | (p[i] & gg);
            gp = gp & p[i];
        end
    end
endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined two-level carry-lookahead adder/subtractor with flags.
module cla_adder_pipe
    import cla_adder_pipe_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] b_x, p1, g1, unused_c1;
    logic [NG-1:0]    gp1, gg1;
    logic [WIDTH-1:0] s1_p, s1_g;
    logic [NG-1:0]    s1_gp, s1_gg, gc;
    logic             s1_c0, s1_valid, tp, tg;
    logic [WIDTH-1:0] cb, sum;
    logic             cout, ovf, zero;
    logic [2:0]       flags;
    logic             s2_ready, adv, acc;

    assign s2_ready = !out_valid | out_ready;
    assign adv = s1_valid & s2_ready;
    assign in_ready = !s1_valid | s2_ready;
    assign acc = in_valid & in_ready;

    assign b_x = in_sub ? ~in_b : in_b;
    assign p1 = in_a ^ b_x;
    assign g1 = in_a & b_x;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group_unit #(.N(GROUP)) u_grp (
            .p   (p1[k*GROUP +: GROUP]),
            .g   (g1[k*GROUP +: GROUP]),
            .cin (1'b0),
            .c   (unused_c1[k*GROUP +: GROUP]),
            .gp  (gp1[k]),
            .gg  (gg1[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_p <= '0;
            s1_g <= '0;
            s1_gp <= '0;
            s1_gg <= '0;
            s1_c0 <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            if (acc) begin
                s1_p <= p1;
                s1_g <= g1;
                s1_gp <= gp1;
                s1_gg <= gg1;
                s1_c0 <= in_sub | in_cin;
            end
            s1_valid <= acc | (s1_valid & ~adv);
        end
    end

    // upper lookahead level over the group P/G yields every group carry at once
    cla_group_unit #(.N(NG)) u_top (
        .p   (s1_gp),
        .g   (s1_gg),
        .cin (s1_c0),
        .c   (gc),
        .gp  (tp),
        .gg  (tg)
    );

    always_comb begin
        cb = '0;
        for (int k = 0; k < NG; k++) begin
            cb[k*GROUP] = gc[k];
            for (int i = 1; i < GROUP; i++)
                cb[k*GROUP+i] = s1_g[k*GROUP+i-1] | (s1_p[k*GROUP+i-1] & cb[k*GROUP+i-1]);
        end
    end

    assign cout = tg | (tp & s1_c0);
    assign sum = s1_p ^ cb;
    assign ovf = cb[WIDTH-1] ^ cout;
    assign zero = ~|sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum <= '0;
            flags <= '0;
            out_valid <= 1'b0;
        end else begin
            if (adv) begin
                out_sum <= sum;
                flags <= {zero, ovf, cout};
            end
            out_valid <= adv | (out_valid & ~out_ready);
        end
    end

    assign out_cout = flags[COUT];
    assign out_ovf = flags[OVF];
    assign out_zero = flags[ZERO];
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: directed-vector self-checking bench for cla_adder_pipe (WIDTH=32, GROUP=4).
module tb_cla_adder_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;
    logic        out_cout, out_ovf, out_zero;

    int checks = 0;
    int failures = 0;

    cla_adder_pipe #(.WIDTH(32), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one beat with out_ready high; result must appear exactly two edges after acceptance
    task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin, input logic [31:0] esum,
                        input logic ecout, input logic eovf, input logic ezero);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        in_cin = cin;
        #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"}, 64'(out_sum), 64'(esum));
        chk({tag, "_cout"}, 64'(out_cout), 64'(ecout));
        chk({tag, "_ovf"}, 64'(out_ovf), 64'(eovf));
        chk({tag, "_zero"}, 64'(out_zero), 64'(ezero));
    endtask

    logic [31:0] exp_bp [4];
    int sent, got;
    logic acc;

    initial begin
        exp_bp[0] = 32'h1000_0000;
        exp_bp[1] = 32'h1000_0001;
        exp_bp[2] = 32'h1000_0002;
        exp_bp[3] = 32'h1000_0003;

        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

        beat("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        beat("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        beat("borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        beat("subeq", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        beat("subeq_cin", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        beat("cin_add", 32'h0000_000F, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        beat("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        beat("subovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // backpressure: four beats, consumer stalled for six cycles then released
        @(negedge clk);
        sent = 0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = (c >= 6);
            if (out_valid) begin
                chk("bp_sum", 64'(out_sum), 64'(exp_bp[got < 4 ? got : 3]));
                if (out_ready) got++;
            end
            in_valid = (sent < 4);
            in_a = 32'(sent);
            in_b = 32'h1000_0000;
            in_sub = 1'b0;
            in_cin = 1'b0;
            #1 acc = in_valid && in_ready;
            if (c == 5) begin
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_accepts", 64'(sent), 64'd2);
            end
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("bp_sent", 64'(sent), 64'd4);
        chk("bp_got", 64'(got), 64'd4);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // reset with two beats in flight
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = 32'h0000_00AA;
            in_b = 32'h0000_0011;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_valid_before", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("mid_async_drop", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("mid_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_no_stale", 64'(out_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
